pdm_mic_frontend: RTL and testbench

- Multi-channel PDM microphone front end; produces the per-mic PCM samples consumed by the delay-and-sum beamformer.
- Generates the shared PDM bit clock and captures one 1-bit PDM line per mic.
- Decimates each channel with a 3rd-order CIC filter and emits unsigned offset-binary BIT_WIDTH samples with a one-cycle valid strobe.

---
 rtl/pdm_mic_frontend.sv | 166 ++++++++++++++++
 tb/tb_pdm_mic_frontend.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_frontend.sv
// pdm_mic_frontend: shared PDM clock generation, per-mic 2-flop capture and
// 3rd-order CIC decimation to unsigned offset-binary PCM lanes.
module pdm_mic_frontend #(
   parameter int NUM_MICS   = 9,
   parameter int BIT_WIDTH  = 8,
   parameter int CLK_DIV    = 4,
   parameter int DECIM_LOG2 = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [NUM_MICS-1:0]           pdm_data_in,
   output logic                          pdm_clk,
   output logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_out,
   output logic                          pcm_valid,
   output logic                          settled
);

   localparam int W    = 3*DECIM_LOG2 + 1;
   localparam int PH_W = $clog2(2*CLK_DIV);
   localparam int R    = 1 << DECIM_LOG2;

   localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(2*CLK_DIV - 1);
   localparam logic [PH_W-1:0]       PH_HIGH  = PH_W'(CLK_DIV);
   localparam logic [DECIM_LOG2-1:0] BC_LAST  = DECIM_LOG2'(R - 1);
   localparam logic [BIT_WIDTH-1:0]  MIDSCALE = {1'b1, {(BIT_WIDTH-1){1'b0}}};
   localparam logic [W-1:0]          FULL     = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

   state_t                  state, state_next;
   logic                    discard_seen, discard_seen_next;
   logic [PH_W-1:0]         ph, ph_next;
   logic [DECIM_LOG2-1:0]   bc;
   logic [NUM_MICS-1:0]     sync1, sync2;
   logic                    active;
   logic                    bit_stb;
   logic                    dec_stb;
   logic                    dec_pend;
   logic                    dec_event;
   logic                    emit;

   // Datapath only runs while enabled outside IDLE; en low clears it at once.
   assign active    = en && (state != IDLE);
   assign bit_stb   = active && (ph == PH_LAST);
   assign dec_stb   = bit_stb && (bc == BC_LAST);
   // Comb stage runs the cycle after the R-th integrator update; dropped if en falls.
   assign dec_event = dec_pend && active;
   assign ph_next   = !active ? '0 : (ph == PH_LAST) ? '0 : ph + 1'b1;
   assign settled   = (state == RUN);

   // FSM state register and settle-discard tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         discard_seen <= 1'b0;
      end else begin
         state        <= state_next;
         discard_seen <= discard_seen_next;
      end
   end

   // FSM next-state: discard two decimation events in SETTLE, then emit in RUN.
   always_comb begin
      state_next        = state;
      discard_seen_next = discard_seen;
      emit              = 1'b0;
      case (state)
         IDLE: begin
            discard_seen_next = 1'b0;
            if (en) state_next = SETTLE;
         end
         SETTLE: begin
            if (!en) begin
               state_next = IDLE;
            end else if (dec_event) begin
               if (discard_seen) state_next = RUN;
               discard_seen_next = 1'b1;
            end
         end
         RUN: begin
            if (!en) state_next = IDLE;
            else     emit = dec_event;
         end
         default: state_next = IDLE;
      endcase
   end

   // Phase/bit counters and registered PDM clock aligned to the current phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph       <= '0;
         bc       <= '0;
         pdm_clk  <= 1'b0;
         dec_pend <= 1'b0;
      end else begin
         ph       <= ph_next;
         pdm_clk  <= active && (ph_next >= PH_HIGH);
         dec_pend <= dec_stb;
         if (!active)      bc <= '0;
         else if (bit_stb) bc <= bc + 1'b1;
      end
   end

   // Two-flop synchronizer on every PDM line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pdm_data_in;
         sync2 <= sync1;
      end
   end

   // Output strobe follows the emitted decimation event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pcm_valid <= 1'b0;
      else     pcm_valid <= emit;
   end

   for (genvar gi = 0; gi < NUM_MICS; gi++) begin : g_chan
      logic [W-1:0]         i1, i2, i3;
      logic [W-1:0]         c1_dly, c2_dly, c3_dly;
      logic [W-1:0]         c1, c2, c3;
      logic [BIT_WIDTH-1:0] lane_val;
      logic [BIT_WIDTH-1:0] lane_q;

      assign c1       = i3 - c1_dly;
      assign c2       = c1 - c2_dly;
      assign c3       = c2 - c3_dly;
      // Full-scale R^3 does not fit the top output bits, so it saturates.
      assign lane_val = (c3 == FULL) ? {BIT_WIDTH{1'b1}} : c3[W-2 -: BIT_WIDTH];

      // Pipelined integrators on bit strobes, combs on decimation events.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            i1 <= '0; i2 <= '0; i3 <= '0;
            c1_dly <= '0; c2_dly <= '0; c3_dly <= '0;
         end else if (!active) begin
            i1 <= '0; i2 <= '0; i3 <= '0;
            c1_dly <= '0; c2_dly <= '0; c3_dly <= '0;
         end else begin
            if (bit_stb) begin
               i1 <= i1 + W'(sync2[gi]);
               i2 <= i2 + i1;
               i3 <= i3 + i2;
            end
            if (dec_event) begin
               c1_dly <= i3;
               c2_dly <= c1;
               c3_dly <= c2;
            end
         end
      end

      // Lane holds its value except when a RUN-state sample is emitted.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)       lane_q <= MIDSCALE;
         else if (emit) lane_q <= lane_val;
      end

      assign pcm_data_out[gi*BIT_WIDTH +: BIT_WIDTH] = lane_q;
   end

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Directed bench for pdm_mic_frontend: table of per-mic input patterns with
// expected PCM lanes, plus en-drop/re-enable and async-reset sequences.
module tb_pdm_mic_frontend;

   localparam int NUM_MICS  = 9;
   localparam int BIT_WIDTH = 8;
   localparam int LW        = NUM_MICS*BIT_WIDTH;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en  = 1'b0;
   logic [NUM_MICS-1:0] pdm_data_in = '0;
   logic                pdm_clk;
   logic [LW-1:0]       pcm_data_out;
   logic                pcm_valid;
   logic                settled;

   pdm_mic_frontend #(
      .NUM_MICS(NUM_MICS), .BIT_WIDTH(BIT_WIDTH), .CLK_DIV(4), .DECIM_LOG2(6)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pdm_data_in(pdm_data_in),
      .pdm_clk(pdm_clk), .pcm_data_out(pcm_data_out),
      .pcm_valid(pcm_valid), .settled(settled)
   );

   always #5 clk = ~clk;

   // modes: 2 bits per mic, 0 = constant 0, 1 = constant 1, 2 = alternating
   typedef struct {
      string        name;
      logic [17:0]  modes;
      logic [LW-1:0] exp;
   } vec_t;

   localparam logic [LW-1:0] MID_ALL = {NUM_MICS{8'h80}};

   vec_t        vecs[6];
   logic [17:0] modes = '0;
   logic        alt_bit = 1'b0;
   logic [2:0]  hist = '0;
   int          rises = 0;
   int          vcount = 0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample on the falling edge, drive the PDM lines for the mode table.
   task automatic tick();
      logic [NUM_MICS-1:0] d;
      @(negedge clk);
      cyc++;
      hist = {hist[1:0], pdm_clk};
      if (hist[1:0] == 2'b01) begin
         rises++;
         alt_bit = ~alt_bit;
      end
      if (pcm_valid) vcount++;
      for (int m = 0; m < NUM_MICS; m++) begin
         case (modes[2*m +: 2])
            2'd0:    d[m] = 1'b0;
            2'd1:    d[m] = 1'b1;
            default: d[m] = alt_bit;
         endcase
      end
      pdm_data_in = d;
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (pcm_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int t0;
      int hi_cnt;
      int v0;

      vecs[0] = '{"all_ones",  {9{2'b01}}, {9{8'hFF}}};
      vecs[1] = '{"all_zeros", {9{2'b00}}, {9{8'h00}}};
      vecs[2] = '{"all_alt",   {9{2'b10}}, {9{8'h80}}};
      vecs[3] = '{"mixed",     {{6{2'b00}}, 2'b10, 2'b00, 2'b01},
                               {{6{8'h00}}, 8'h80, 8'h00, 8'hFF}};
      vecs[4] = '{"alt_hi8",   {2'b01, {8{2'b10}}}, {8'hFF, {8{8'h80}}}};
      vecs[5] = '{"odd_even",  {2'b01, {4{2'b00, 2'b01}}}, {8'hFF, {4{8'h00, 8'hFF}}}};

      for (int v = 0; v < 6; v++) begin
         en  = 1'b0;
         rst = 1'b1;
         modes = vecs[v].modes;
         repeat (3) tick();
         chk("reset_pdm_clk", pdm_clk, 0);
         chk("reset_valid", pcm_valid, 0);
         chk("reset_settled", settled, 0);
         chk("reset_lanes", pcm_data_out, MID_ALL);
         rst = 1'b0;
         tick();
         en = 1'b1;
         rises = 0;
         vcount = 0;
         repeat (1000) tick();
         chk("settle_no_valid", vcount, 0);
         chk("settle_flag_low", settled, 0);
         chk("settle_lanes_mid", pcm_data_out, MID_ALL);
         wait_valid(2000, ok);
         chk("first_valid_seen", ok, 1);
         chk("first_valid_bits", rises, 192);
         chk("valid_after_stb", hist, 3'b100);
         chk({vecs[v].name, "_lanes1"}, pcm_data_out, vecs[v].exp);
         chk("settled_high", settled, 1);
         t0 = cyc;
         tick();
         chk("valid_width", pcm_valid, 0);
         wait_valid(700, ok);
         chk("second_valid_seen", ok, 1);
         chk("valid_spacing", cyc - t0, 512);
         chk({vecs[v].name, "_lanes2"}, pcm_data_out, vecs[v].exp);
         $display("vector %0d %s: lanes=%0h", v, vecs[v].name, pcm_data_out);
      end

      // en dropped mid-RUN, re-raised 100 cycles later
      repeat (100) tick();
      en = 1'b0;
      tick();
      chk("drop_pdm_clk_low", pdm_clk, 0);
      chk("drop_settled_low", settled, 0);
      chk("drop_lanes_held", pcm_data_out, vecs[5].exp);
      hi_cnt = 0;
      v0 = vcount;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (pdm_clk) hi_cnt++;
      end
      chk("idle_pdm_clk_quiet", hi_cnt, 0);
      chk("idle_no_valid", vcount - v0, 0);
      chk("idle_lanes_held", pcm_data_out, vecs[5].exp);
      en = 1'b1;
      rises = 0;
      wait_valid(3000, ok);
      chk("reen_valid_seen", ok, 1);
      chk("reen_discards", rises, 192);
      chk("reen_lanes", pcm_data_out, vecs[5].exp);
      $display("re-enable: lanes=%0h after %0d bits", pcm_data_out, rises);

      // async reset in the middle of SETTLE, during a pdm_clk high phase
      en = 1'b0;
      tick();
      en = 1'b1;
      repeat (600) tick();
      for (int i = 0; i < 10 && !pdm_clk; i++) tick();
      chk("settle_pdm_clk_high", pdm_clk, 1);
      chk("settle_lanes_held", pcm_data_out, vecs[5].exp);
      rst = 1'b1;
      #1;
      chk("async_rst_pdm_clk", pdm_clk, 0);
      chk("async_rst_valid", pcm_valid, 0);
      chk("async_rst_settled", settled, 0);
      chk("async_rst_lanes", pcm_data_out, MID_ALL);
      $display("async reset: lanes=%0h pdm_clk=%0b", pcm_data_out, pdm_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
